systolic_sequencer: RTL and testbench

SYSTOLIC_SEQUENCER -- requirements
Module: systolic_sequencer

---
 rtl/systolic_sequencer_if.sv | 24 ++
 rtl/systolic_sequencer.sv | 79 +++++++
 tb/tb_systolic_sequencer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/systolic_sequencer_if.sv
// systolic_sequencer_if: job request inputs and buffer/array/drain strobes of the systolic sequencer
interface systolic_sequencer_if;
    logic       start;
    logic       abort;
    logic [6:0] k_len;
    logic       mode_in;
    logic       buf_rd_en;
    logic [6:0] buf_rd_addr;
    logic       array_valid;
    logic       i_mode;
    logic       acc_clear;
    logic       drain_en;
    logic [3:0] drain_addr;
    logic       busy;
    logic       done;
    modport master (
        output start, abort, k_len, mode_in,
        input  buf_rd_en, buf_rd_addr, array_valid, i_mode, acc_clear, drain_en, drain_addr, busy, done
    );
    modport slave (
        input  start, abort, k_len, mode_in,
        output buf_rd_en, buf_rd_addr, array_valid, i_mode, acc_clear, drain_en, drain_addr, busy, done
    );
endinterface

// File: rtl/systolic_sequencer.sv
// systolic_sequencer: clear/stream/flush/drain job sequencer for a systolic array, all outputs registered
module systolic_sequencer #(
    parameter int ARRAY_DIM = 4,
    parameter int DRAIN_LEN = 16
) (
    input logic                    clk,
    input logic                    rst,
    systolic_sequencer_if.slave    bus
);
    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, FLUSH, DRAIN, DONE} state_t;
    localparam logic [6:0] FLUSH_LAST = 7'(2 * ARRAY_DIM - 2);
    localparam logic [6:0] DRAIN_LAST = 7'(DRAIN_LEN - 1);
    state_t     state, nstate;
    logic [6:0] cnt, ncnt, k_reg;
    logic       accept;
    logic       rd_en_d, clr_d, drain_en_d, busy_d, done_d;
    logic [6:0] rd_addr_d;
    logic [3:0] drain_addr_d;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            k_reg <= '0;
        end else begin
            state <= nstate;
            cnt   <= ncnt;
            if (accept) k_reg <= bus.k_len;
        end
    end
    always_comb begin
        accept = state == IDLE && bus.start && !bus.abort;
        nstate = state;
        unique case (state)
            IDLE:    if (accept) nstate = (bus.k_len != 7'd0) ? CLEAR : DONE;
            CLEAR:   nstate = STREAM;
            STREAM:  if (cnt == k_reg - 7'd1) nstate = FLUSH;
            FLUSH:   if (cnt == FLUSH_LAST) nstate = DRAIN;
            DRAIN:   if (cnt == DRAIN_LAST) nstate = DONE;
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
        if (bus.abort && state != IDLE) nstate = IDLE;
        // the counter restarts on every state change so each phase counts from 0
        ncnt = (nstate != state || state == IDLE) ? 7'd0 : cnt + 7'd1;
    end
    always_comb begin
        clr_d        = nstate == CLEAR;
        rd_en_d      = nstate == STREAM;
        rd_addr_d    = rd_en_d ? ncnt : 7'd0;
        drain_en_d   = nstate == DRAIN;
        drain_addr_d = drain_en_d ? ncnt[3:0] : 4'd0;
        busy_d       = nstate != IDLE;
        done_d       = nstate == DONE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.acc_clear   <= 1'b0;
            bus.buf_rd_en   <= 1'b0;
            bus.buf_rd_addr <= '0;
            bus.array_valid <= 1'b0;
            bus.drain_en    <= 1'b0;
            bus.drain_addr  <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.i_mode      <= 1'b0;
        end else begin
            bus.acc_clear   <= clr_d;
            bus.buf_rd_en   <= rd_en_d;
            bus.buf_rd_addr <= rd_addr_d;
            // one-cycle buffer read latency; killed immediately on abort
            bus.array_valid <= bus.buf_rd_en && nstate != IDLE;
            bus.drain_en    <= drain_en_d;
            bus.drain_addr  <= drain_addr_d;
            bus.busy        <= busy_d;
            bus.done        <= done_d;
            if (accept) bus.i_mode <= bus.mode_in;
        end
    end
endmodule

// File: tb/tb_systolic_sequencer.sv
// tb_systolic_sequencer: directed jobs checked every cycle against a job-timeline model plus literal expectations
module tb_systolic_sequencer;
    localparam int AD = 4;
    localparam int DL = 16;
    localparam int FL = 2 * AD - 1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    systolic_sequencer_if sif();
    systolic_sequencer #(.ARRAY_DIM(AD), .DRAIN_LEN(DL)) dut (.clk(clk), .rst(rst), .bus(sif));
    always #5 clk = ~clk;

    int vectors = 0, errors = 0;
    int cyc = 0, s = 0;
    bit act = 0, mm = 0;
    int t = 0, kk = 0;
    int n_busy, n_rd, n_val, n_clr, n_dr, n_done, max_addr, done_at;

    function automatic int job_end(int k);
        return (k == 0) ? 1 : k + FL + DL + 2;
    endfunction

    // model: a job is a timeline t = 1..end after the accepting edge; outputs are plain ranges of t
    always @(posedge clk) begin
        logic [17:0] e, a;
        bit live, rd, dr;
        if (rst) begin
            act = 0;
            mm = 0;
        end else if (act) begin
            if (sif.abort || t == job_end(kk)) act = 0;
            else t++;
        end else if (sif.start && !sif.abort) begin
            act = 1;
            t = 1;
            kk = int'(sif.k_len);
            mm = sif.mode_in;
        end
        cyc++;
        #1;
        live = act && kk != 0;
        rd = live && t >= 2 && t <= kk + 1;
        dr = live && t >= kk + FL + 2 && t <= kk + FL + DL + 1;
        e = {live && t == 1, rd, rd ? 7'(t - 2) : 7'd0, live && t >= 3 && t <= kk + 2,
             dr, dr ? 4'(t - kk - FL - 2) : 4'd0, act, act && t == job_end(kk), mm};
        a = {sif.acc_clear, sif.buf_rd_en, sif.buf_rd_addr, sif.array_valid,
             sif.drain_en, sif.drain_addr, sif.busy, sif.done, sif.i_mode};
        vectors++;
        if (a !== e) begin
            errors++;
            $display("FAIL cycle %0d outputs {clr,rd,addr,val,dr,daddr,busy,done,mode}: got %h want %h", cyc, a, e);
        end
        n_busy += int'(sif.busy);
        n_rd += int'(sif.buf_rd_en);
        n_val += int'(sif.array_valid);
        n_clr += int'(sif.acc_clear);
        n_dr += int'(sif.drain_en);
        if (sif.buf_rd_en && int'(sif.buf_rd_addr) > max_addr) max_addr = int'(sif.buf_rd_addr);
        if (sif.done) begin
            n_done++;
            done_at = cyc - s;
        end
    end

    task automatic chk(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic clr_mon();
        @(negedge clk);
        {n_busy, n_rd, n_val, n_clr, n_dr, n_done, max_addr, done_at} = '0;
    endtask

    task automatic job(input int k, input bit m);
        sif.start = 1'b1;
        sif.k_len = 7'(k);
        sif.mode_in = m;
        s = cyc;
        @(negedge clk);
        sif.start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        bit ok = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (!sif.busy) begin
                ok = 1;
                break;
            end
        end
        chk({name, " idle within bound"}, int'(ok), 1);
    endtask

    initial begin
        sif.start = 1'b0;
        sif.abort = 1'b0;
        sif.k_len = '0;
        sif.mode_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy", int'(sif.busy), 0);
        chk("reset i_mode", int'(sif.i_mode), 0);
        rst = 1'b0;
        // basic job
        clr_mon();
        job(3, 1);
        wait_idle("basic", 40);
        chk("basic done cycle", done_at, 28);
        chk("basic busy cycles", n_busy, 28);
        chk("basic reads", n_rd, 3);
        chk("basic valid", n_val, 3);
        chk("basic clears", n_clr, 1);
        chk("basic drains", n_dr, 16);
        chk("basic done pulses", n_done, 1);
        chk("basic i_mode", int'(sif.i_mode), 1);
        // zero length
        clr_mon();
        job(0, 0);
        wait_idle("zero", 5);
        chk("zero done cycle", done_at, 1);
        chk("zero clr+rd+dr", n_clr + n_rd + n_dr, 0);
        chk("zero i_mode", int'(sif.i_mode), 0);
        // start while busy, then start during DONE
        clr_mon();
        job(3, 1);
        @(negedge clk);
        job(5, 0);
        for (int i = 0; i < 40 && !sif.done; i++) @(negedge clk);
        sif.start = 1'b1;
        sif.k_len = 7'd2;
        @(negedge clk);
        sif.start = 1'b0;
        chk("start in done ignored", int'(sif.busy), 0);
        chk("busy start reads", n_rd, 3);
        chk("busy start dones", n_done, 1);
        chk("busy start i_mode", int'(sif.i_mode), 1);
        // abort in DRAIN at drain_addr 6
        clr_mon();
        job(2, 0);
        for (int i = 0; i < 40 && !(sif.drain_en && sif.drain_addr == 4'd6); i++) @(negedge clk);
        sif.abort = 1'b1;
        @(negedge clk);
        sif.abort = 1'b0;
        chk("abort busy", int'(sif.busy), 0);
        chk("abort drains", n_dr, 7);
        chk("abort dones", n_done, 0);
        clr_mon();
        job(1, 1);
        wait_idle("after abort", 40);
        chk("after abort done cycle", done_at, 26);
        // abort and start together in IDLE
        sif.abort = 1'b1;
        job(4, 0);
        sif.abort = 1'b0;
        chk("abort+start not accepted", int'(sif.busy), 0);
        chk("abort+start i_mode kept", int'(sif.i_mode), 1);
        // reset during FLUSH
        clr_mon();
        job(2, 1);
        for (int i = 0; i < 40 && !(sif.array_valid && !sif.buf_rd_en); i++) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst busy", int'(sif.busy), 0);
        chk("rst i_mode", int'(sif.i_mode), 0);
        chk("rst dones", n_done, 0);
        clr_mon();
        job(4, 0);
        wait_idle("after rst", 40);
        chk("after rst done cycle", done_at, 29);
        chk("after rst clears", n_clr, 1);
        // maximum length
        clr_mon();
        job(127, 1);
        wait_idle("max", 200);
        chk("max done cycle", done_at, 152);
        chk("max reads", n_rd, 127);
        chk("max last addr", max_addr, 126);
        chk("max valid", n_val, 127);
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
